poly_tone_mixer: RTL and testbench

POLY_TONE_MIXER -- requirements
Module: poly_tone_mixer

---
 rtl/tone_pkg.sv | 23 ++
 rtl/wave_shaper.sv | 29 ++
 rtl/poly_tone_mixer.sv | 166 ++++++++++++++++
 tb/tb_poly_tone_mixer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the polyphonic tone mixer: waveform
// encodings, mixer FSM states and the square-wave amplitude limits.
`default_nettype none

package tone_pkg;

    localparam logic [1:0] WAVE_SQUARE   = 2'b00;
    localparam logic [1:0] WAVE_TRIANGLE = 2'b01;
    localparam logic [1:0] WAVE_SAWTOOTH = 2'b10;
    localparam logic [1:0] WAVE_SILENT   = 2'b11;

    localparam logic signed [15:0] SQUARE_HIGH = 16'sd32767;
    localparam logic signed [15:0] SQUARE_LOW  = -16'sd32767;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LOAD  = 2'd2
    } mix_state_t;

endpackage

`default_nettype wire

// File: rtl/wave_shaper.sv
// Combinational phase-to-amplitude mapping for one voice, driven by the
// top 16 bits of the voice phase accumulator.
`default_nettype none

module wave_shaper
    import tone_pkg::*;
(
    input  logic [15:0]        phase_hi,
    input  logic [1:0]         wave_sel,
    output logic signed [15:0] value
);

    logic [14:0] tri_level;

    always_comb begin
        tri_level = phase_hi[15] ? ~phase_hi[14:0] : phase_hi[14:0];
        value     = '0;
        case (wave_sel)
            WAVE_SQUARE:   value = phase_hi[15] ? SQUARE_LOW : SQUARE_HIGH;
            // Modulo-2^16 subtraction yields the correct two's-complement result.
            WAVE_TRIANGLE: value = {tri_level, 1'b0} - 16'h8000;
            WAVE_SAWTOOTH: value = {~phase_hi[15], phase_hi[14:0]};
            default:       value = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/poly_tone_mixer.sv
// Polyphonic tone generator: per-voice phase accumulators and waveforms,
// serially summed once per sample tick, saturated and handed downstream.
`default_nettype none

module poly_tone_mixer
    import tone_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 32,
    parameter int GAIN_SHIFT = 12,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_VOICES-1:0]     play_note,
    input  logic [NUM_VOICES*32-1:0]  phase_inc,
    input  logic [NUM_VOICES*2-1:0]   wave_sel,
    input  logic                      audio_out_allowed,
    output logic [SAMPLE_W-1:0]       audio_out,
    output logic                      write_audio_out,
    output logic                      clip,
    output logic [15:0]               drop_count
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int EXT_W = ACC_W - SAMPLE_W + 1;

    localparam logic [IDX_W-1:0]    LAST_VOICE = IDX_W'(NUM_VOICES - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [SAMPLE_W-1:0] SAT_MAX    = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_MIN    = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    mix_state_t              state;
    mix_state_t              next_state;
    logic [IDX_W-1:0]        voice_idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] wave_ext;
    logic signed [ACC_W-1:0] voice_term;
    logic [NUM_VOICES-1:0]   play_prev;
    logic signed [15:0]      voice_wave [NUM_VOICES];
    logic                    sum_fits;
    logic [SAMPLE_W-1:0]     sat_value;
    logic                    pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            play_prev <= '0;
        end else begin
            play_prev <= play_note;
        end
    end

    // Each voice advances in the ACCUM cycle that consumes it, so the sum
    // always sees the phase from before this tick's increment.
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        logic [31:0] phase;

        always_ff @(posedge clock) begin
            if (reset) begin
                phase <= '0;
            end else if (play_note[i] && !play_prev[i]) begin
                phase <= '0;
            end else if (state == ACCUM && voice_idx == IDX_W'(i)) begin
                phase <= phase + phase_inc[32*i +: 32];
            end
        end

        wave_shaper u_shaper (
            .phase_hi (phase[31:16]),
            .wave_sel (wave_sel[2*i +: 2]),
            .value    (voice_wave[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick) next_state = ACCUM;
            ACCUM:   if (voice_idx == LAST_VOICE) next_state = LOAD;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wave_ext   = {{(ACC_W-16){voice_wave[voice_idx][15]}}, voice_wave[voice_idx]};
        voice_term = '0;
        if (play_note[voice_idx]) begin
            voice_term = wave_ext <<< GAIN_SHIFT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            voice_idx <= '0;
        end else if (state == ACCUM) begin
            acc       <= acc + voice_term;
            voice_idx <= voice_idx + 1'b1;
        end else begin
            acc       <= '0;
            voice_idx <= '0;
        end
    end

    always_comb begin
        sum_fits  = (&acc[ACC_W-1:SAMPLE_W-1]) || !(|acc[ACC_W-1:SAMPLE_W-1]);
        sat_value = acc[SAMPLE_W-1:0];
        if (!sum_fits) begin
            sat_value = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign write_audio_out = pending && audio_out_allowed && !reset;

    // A new sample wins over a same-cycle transfer: the old one still leaves.
    always_ff @(posedge clock) begin
        if (reset) begin
            audio_out  <= '0;
            clip       <= 1'b0;
            pending    <= 1'b0;
            drop_count <= '0;
        end else if (state == LOAD) begin
            audio_out <= sat_value;
            clip      <= !sum_fits;
            pending   <= 1'b1;
            if (pending && !audio_out_allowed && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (write_audio_out) begin
            pending <= 1'b0;
        end
    end

    // Keeps EXT_W referenced for readers sizing the headroom check.
    if (EXT_W < 2) begin : g_width_guard
        $error("accumulator must have headroom above SAMPLE_W");
    end

endmodule

`default_nettype wire

// File: tb/tb_poly_tone_mixer.sv
// Randomized and directed bench for poly_tone_mixer with a per-tick
// arithmetic reference model, at GAIN_SHIFT 12 and 16.
`default_nettype none

module tb_poly_tone_mixer;

    localparam int NV  = 4;
    localparam int DIV = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   play_note = '0;
    logic [127:0] phase_inc = '0;
    logic [7:0]   wave_sel = '0;
    logic         audio_out_allowed = 1'b0;
    logic [31:0]  out_a, out_b;
    logic         wr_a, wr_b, clip_a, clip_b;
    logic [15:0]  drop_a, drop_b;

    always #5 clock = ~clock;

    poly_tone_mixer #(.NUM_VOICES(NV), .SAMPLE_W(32), .GAIN_SHIFT(12), .SAMPLE_DIV(DIV)) dut_a (
        .clock(clock), .reset(reset), .play_note(play_note), .phase_inc(phase_inc),
        .wave_sel(wave_sel), .audio_out_allowed(audio_out_allowed), .audio_out(out_a),
        .write_audio_out(wr_a), .clip(clip_a), .drop_count(drop_a));

    poly_tone_mixer #(.NUM_VOICES(NV), .SAMPLE_W(32), .GAIN_SHIFT(16), .SAMPLE_DIV(DIV)) dut_b (
        .clock(clock), .reset(reset), .play_note(play_note), .phase_inc(phase_inc),
        .wave_sel(wave_sel), .audio_out_allowed(audio_out_allowed), .audio_out(out_b),
        .write_audio_out(wr_b), .clip(clip_b), .drop_count(drop_b));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes  = 0;

    logic [31:0] m_phase [NV];
    logic [3:0]  m_play = '0;
    longint      m_out [2];
    bit          m_clip [2];
    longint      m_new [2];
    bit          m_newclip [2];
    bit          m_pend;
    int          m_drop;
    bit          m_due_valid;
    int          m_due;
    longint      q_a [$];
    longint      q_b [$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint voice_val(input logic [31:0] ph32, input logic [1:0] sel);
        longint ph;
        ph = longint'(ph32 >> 16);
        case (sel)
            2'b00:   return (ph < 32768) ? 32767 : -32767;
            2'b01:   return (ph < 32768) ? 2 * ph - 32768 : 2 * (65535 - ph) - 32768;
            2'b10:   return ph - 32768;
            default: return 0;
        endcase
    endfunction

    task automatic make_sample();
        for (int g = 0; g < 2; g++) begin
            longint sum;
            sum = 0;
            for (int v = 0; v < NV; v++) begin
                if (m_play[v]) sum += voice_val(m_phase[v], wave_sel[2*v +: 2]) * (longint'(1) << (g ? 16 : 12));
            end
            m_newclip[g] = 1'b0;
            if (sum > 64'sd2147483647) begin
                sum = 64'sd2147483647;
                m_newclip[g] = 1'b1;
            end else if (sum < -64'sd2147483648) begin
                sum = -64'sd2147483648;
                m_newclip[g] = 1'b1;
            end
            m_new[g] = sum;
        end
        for (int v = 0; v < NV; v++) m_phase[v] = m_phase[v] + phase_inc[32*v +: 32];
    endtask

    task automatic step();
        #1;
        chk("strobe_a", wr_a, m_pend && audio_out_allowed);
        chk("strobe_b", wr_b, m_pend && audio_out_allowed);
        chk("out_a", $signed(out_a), m_out[0]);
        chk("out_b", $signed(out_b), m_out[1]);
        chk("clip_a", clip_a, m_clip[0]);
        chk("clip_b", clip_b, m_clip[1]);
        chk("drop_a", drop_a, m_drop);
        chk("drop_b", drop_b, m_drop);
        if (wr_a) begin
            q_a.push_back(longint'($signed(out_a)));
            strobes++;
        end
        if (wr_b) q_b.push_back(longint'($signed(out_b)));
        if (cyc % DIV == 0) begin
            make_sample();
            m_due_valid = 1'b1;
            m_due       = cyc + 5;
        end
        if (m_due_valid && m_due == cyc) begin
            if (m_pend && !audio_out_allowed && m_drop < 65535) m_drop++;
            for (int g = 0; g < 2; g++) begin
                m_out[g]  = m_new[g];
                m_clip[g] = m_newclip[g];
            end
            m_pend      = 1'b1;
            m_due_valid = 1'b0;
        end else if (m_pend && audio_out_allowed) begin
            m_pend = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic goto_off(input int off);
        while (cyc % DIV != off) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int v = 0; v < NV; v++) m_phase[v] = '0;
        for (int g = 0; g < 2; g++) begin
            m_out[g]  = 0;
            m_clip[g] = 1'b0;
        end
        m_pend      = 1'b0;
        m_drop      = 0;
        m_due_valid = 1'b0;
        cyc         = 0;
    endtask

    task automatic set_play(input logic [3:0] v);
        for (int i = 0; i < NV; i++) if (v[i] && !m_play[i]) m_phase[i] = '0;
        m_play    = v;
        play_note = v;
    endtask

    task automatic set_voice(input int i, input logic [31:0] inc, input logic [1:0] sel);
        phase_inc[32*i +: 32] = inc;
        wave_sel[2*i +: 2]    = sel;
    endtask

    initial begin
        // Reset for 5 clocks, then one divider period with no transfers.
        do_reset(5);
        #1;
        chk("reset_out", out_a, 0);
        chk("reset_strobe", wr_a, 0);
        chk("reset_clip", clip_b, 0);
        chk("reset_drop", drop_a, 0);
        strobes = 0;
        run(16);
        chk("idle_no_strobe", strobes, 0);

        // Single square voice at GAIN_SHIFT 12.
        audio_out_allowed = 1'b1;
        set_voice(0, 32'h1000_0000, 2'b00);
        goto_off(10);
        set_play(4'b0001);
        q_a.delete();
        run(16 * DIV);
        chk("square_count", q_a.size(), 16);
        for (int i = 0; i < q_a.size() && i < 16; i++)
            chk("square_sample", q_a[i], (i < 8) ? 134213632 : -134213632);

        // Sawtooth across four quarter-turn phases.
        goto_off(10);
        set_play(4'b0000);
        set_voice(0, 32'h4000_0000, 2'b10);
        step();
        set_play(4'b0001);
        q_a.delete();
        run(64);
        chk("saw_count", q_a.size(), 4);
        if (q_a.size() == 4) begin
            chk("saw_0", q_a[0], -134217728);
            chk("saw_1", q_a[1], -67108864);
            chk("saw_2", q_a[2], 0);
            chk("saw_3", q_a[3], 67108864);
        end

        // Saturation at GAIN_SHIFT 16.
        goto_off(10);
        set_play(4'b0000);
        for (int v = 0; v < NV; v++) set_voice(v, 32'h0, 2'b00);
        step();
        set_play(4'b1111);
        goto_off(7);
        chk("sat4_out", $signed(out_b), 2147483647);
        chk("sat4_clip", clip_b, 1);
        chk("sat4_gain12", $signed(out_a), 536854528);
        goto_off(10);
        set_play(4'b0011);
        goto_off(7);
        chk("sat2_out", $signed(out_b), 2147483647);
        chk("sat2_clip", clip_b, 1);
        goto_off(10);
        set_play(4'b0001);
        goto_off(7);
        chk("one_out", $signed(out_b), 2147418112);
        chk("one_clip", clip_b, 0);

        // Back-pressure over three loads, then release.
        set_play(4'b0000);
        set_voice(0, 32'h4000_0000, 2'b01);
        step();
        set_play(4'b0001);
        audio_out_allowed = 1'b0;
        strobes = 0;
        goto_off(0);
        goto_off(8);
        goto_off(0);
        goto_off(8);
        goto_off(0);
        goto_off(8);
        chk("bp_no_strobe", strobes, 0);
        chk("bp_drops", drop_a, 2);
        audio_out_allowed = 1'b1;
        q_a.delete();
        goto_off(15);
        chk("bp_one_strobe", strobes, 1);
        if (q_a.size() == 1) chk("bp_third_sample", q_a[0], 134209536);

        // Reset two cycles into accumulation discards the partial sum.
        set_voice(0, 32'h1000_0000, 2'b00);
        goto_off(2);
        do_reset(1);
        strobes = 0;
        q_a.delete();
        run(5);
        #1;
        chk("midrst_out", out_a, 0);
        chk("midrst_no_strobe", strobes, 0);
        step();
        step();
        chk("midrst_strobe", strobes, 1);
        if (q_a.size() == 1) chk("midrst_sample", q_a[0], 134213632);

        // Randomized voices, waveforms and back-pressure.
        for (int w = 0; w < 10; w++) begin
            goto_off(8);
            for (int v = 0; v < NV; v++) set_voice(v, $urandom, 2'($urandom_range(0, 3)));
            set_play(4'($urandom_range(0, 15)));
            for (int k = 0; k < DIV; k++) begin
                audio_out_allowed = 1'($urandom_range(0, 1));
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
